conv_lif_accum: RTL and testbench
=================================

CONV_LIF_ACCUM -- requirements
Module: conv_lif_accum

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter N_NEURON, 64, number of LIF neurons; the block SHALL hold one membrane register per neuron.
REQ-003 Parameter IDX_W, 6, neuron address width; log2(N_NEURON).
REQ-004 Parameter V_W, 12, membrane width, unsigned.
REQ-005 Parameter THRESH, 100, firing threshold.
REQ-006 Parameter W_INC, 10, membrane increment per event.
REQ-007 Parameter LEAK, 1, per-step leak amount.
REQ-008 clk  in  1  system clock, rising edge.
REQ-009 rst  in  1  asynchronous reset, active-high.
REQ-010 s_index_i  in  `SYNAPSE_INDEX  event word from the upstream conv FIFO; bits [IDX_W-1:0] give the target neuron, upper bits are ignored.
REQ-011 empty  in  1  upstream FIFO empty.
REQ-012 almost_empty  in  1  upstream FIFO holds exactly one word.
REQ-013 r_en  out  1  upstream FIFO read; data is valid on s_index_i in the cycle after r_en.
REQ-014 step_end  in  1  single-cycle pulse marking the end of the current timestep.
REQ-015 full  in  1  downstream FIFO full.
REQ-016 w_en  out  1  downstream FIFO write strobe.
REQ-017 s_index_o  out  `SYNAPSE_INDEX  index of the firing neuron, zero-extended; valid while w_en is high.
REQ-018 step_done  out  1  single-cycle pulse when a sweep completes.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 The FSM SHALL have four states: IDLE, ACCUM, SWEEP, DONE.
REQ-021 Transitions:
- IDLE->ACCUM when !empty.
- IDLE->SWEEP when step_end is pending and no read is in flight.
- ACCUM->IDLE when empty and no read is in flight.
- SWEEP->DONE after neuron N_NEURON-1 is processed.
- DONE->IDLE after one cycle.
REQ-022 Read rule: r_en = (state is IDLE or ACCUM) && !empty && !(almost_empty && read_in_flight) && !step_pending_drained. This prevents over-reading the last word.
REQ-023 On each valid word, the addressed membrane SHALL become min(V + W_INC, 2^V_W-1), updated at the second rising edge after r_en (latency 2).
REQ-024 Back-to-back events to the same neuron SHALL accumulate correctly with no lost updates (read-modify-write completes in one cycle).
REQ-025 step_end SHALL set a single pending flag. Further pulses before DONE are absorbed. The flag clears in DONE.
REQ-026 While step_end is pending, reads SHALL continue until the FIFO is empty. SWEEP SHALL then start with no further reads until DONE.
REQ-027 SWEEP visits neurons 0..N_NEURON-1, one per cycle.
- Neuron with V >= THRESH: fires. w_en=1, s_index_o=index, V<=0.
- If a firing neuron meets full=1: the sweep SHALL stall on that neuron, with no write and no membrane change, until full=0.
- Non-firing neurons advance regardless of full.
REQ-028 w_en SHALL never be asserted while full=1. r_en SHALL be 0 during SWEEP and DONE.
REQ-029 step_done SHALL pulse for exactly one cycle in DONE.
REQ-030 An event arriving during SWEEP SHALL remain in the upstream FIFO for the next timestep.

Reset
REQ-031 On rst, these SHALL clear immediately: state=IDLE, all membranes=0, pending flag, read_in_flight, sweep counter.
REQ-032 On rst, these outputs SHALL be 0 immediately: r_en, w_en, s_index_o, step_done, busy.
REQ-033 A reset mid-ACCUM or mid-SWEEP SHALL discard all partial state. An in-flight FIFO word is dropped.

Configuration
REQ-034 Macro LIF_LEAK_EN SHALL control leak. When defined, each non-firing neuron in SWEEP SHALL get V<=max(V-LEAK,0). When undefined, non-firing membranes are unchanged and the LEAK parameter is unused.

Verification
REQ-035 Five events to neuron 3, then step_end -> after 2 cycles V[3]=50; sweep emits no write; step_done 1 pulse; V[3]=49 with LIF_LEAK_EN, 50 without.
REQ-036 Ten events to neuron 7, then step_end -> one w_en with s_index_o=7; V[7]=0; sweep lasts 64 cycles.
REQ-037 Neurons 0 and 63 over threshold, full held high for 5 cycles when neuron 0 is reached -> w_en is first asserted 5 cycles later for index 0; index 63 follows; sweep lasts 69 cycles.
REQ-038 Single word in FIFO (almost_empty=1) -> exactly one r_en pulse; no underflow read.
REQ-039 500 events to neuron 1 -> V[1] saturates at 4095 with no wrap; fires at sweep.
REQ-040 rst asserted mid-SWEEP at neuron 20 -> all outputs 0 in the same cycle; next sweep emits nothing.

Source files
------------

// File: rtl/conv_lif_accum_if.sv
// Event/spike bus between the upstream conv FIFO, the LIF accumulator and the downstream FIFO.
// Latency: n/a (wires only).
// Backpressure: upstream is pulled with r_en/empty/almost_empty, downstream is pushed with w_en/full.
//
// Ports (slave = accumulator side):
//   s_index_i, empty, almost_empty, step_end, full : into the accumulator
//   r_en, w_en, s_index_o, step_done, busy         : out of the accumulator

`ifndef SYNAPSE_INDEX
`define SYNAPSE_INDEX 15:0
`endif

interface conv_lif_accum_if;
    logic [`SYNAPSE_INDEX] s_index_i;
    logic                  empty;
    logic                  almost_empty;
    logic                  r_en;
    logic                  step_end;
    logic                  full;
    logic                  w_en;
    logic [`SYNAPSE_INDEX] s_index_o;
    logic                  step_done;
    logic                  busy;

    modport slave (
        input  s_index_i, empty, almost_empty, step_end, full,
        output r_en, w_en, s_index_o, step_done, busy
    );

    modport master (
        output s_index_i, empty, almost_empty, step_end, full,
        input  r_en, w_en, s_index_o, step_done, busy
    );
endinterface

// File: rtl/conv_lif_accum.sv
// Leaky integrate-and-fire accumulator: integrates conv events into per-neuron membranes and
// sweeps all neurons at each timestep end, emitting the indices of neurons that fire.
// Latency: a membrane updates 2 edges after its r_en; a sweep takes N_NEURON cycles plus stalls.
// Backpressure: a firing neuron holds the sweep while full=1; events arriving during a sweep stay
// in the upstream FIFO until the sweep is done.
//
// Ports: clk, rst (async, active-high); lif (conv_lif_accum_if.slave) carries the upstream read
// interface, step_end, the downstream write interface, step_done and busy.
// Optional feature: define LIF_LEAK_EN to leak non-firing membranes by LEAK during each sweep.

`ifndef SYNAPSE_INDEX
`define SYNAPSE_INDEX 15:0
`endif

module conv_lif_accum #(
    parameter int N_NEURON = 64,
    parameter int IDX_W    = 6,
    parameter int V_W      = 12,
    parameter int THRESH   = 100,
    parameter int W_INC    = 10,
    parameter int LEAK     = 1
) (
    input  logic            clk,
    input  logic            rst,
    conv_lif_accum_if.slave lif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } state_t;

`ifdef LIF_LEAK_EN
    localparam bit LEAK_ON = 1'b1;
`else
    localparam bit LEAK_ON = 1'b0;
`endif

    // With leak disabled the leak amount collapses to zero, so the sweep leaves
    // non-firing membranes untouched.
    localparam logic [V_W-1:0]   LEAK_V   = LEAK_ON ? V_W'(LEAK) : '0;
    localparam logic [V_W-1:0]   THRESH_V = V_W'(THRESH);
    localparam logic [V_W:0]     W_INC_V  = (V_W+1)'(W_INC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEURON - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t           state_q, state_d;
    logic             pend_q, pend_d;       // step_end seen, sweep not yet finished
    logic             drained_q, drained_d; // pending step saw the FIFO empty: stop reading
    logic             rif_q;                // read in flight: word lands on s_index_i this cycle
    logic [IDX_W-1:0] idx_q, idx_d;         // sweep counter
    logic [V_W-1:0]   v_q [N_NEURON];

    logic [`SYNAPSE_INDEX] sidx_in;
    logic                  unused_sidx_in;
    logic [IDX_W-1:0]      rd_idx;
    logic [V_W-1:0]        v_rd, v_inc, v_cur, v_leak;
    logic [V_W:0]          inc_sum;
    logic                  fire;
    logic                  rd_en;
    logic                  wr_en;
    logic                  sweep_upd;
    logic                  done_pulse;
    logic [`SYNAPSE_INDEX] sidx_out;

    // Only the low IDX_W bits address a neuron; the rest of the word is ignored.
    assign sidx_in        = lif.s_index_i;
    assign rd_idx         = sidx_in[IDX_W-1:0];
    assign unused_sidx_in = ^sidx_in;

    // Saturating accumulate. Reading the current value combinationally and writing
    // it back in the same edge keeps back-to-back hits to one neuron exact.
    assign v_rd    = v_q[rd_idx];
    assign inc_sum = {1'b0, v_rd} + W_INC_V;
    assign v_inc   = inc_sum[V_W] ? {V_W{1'b1}} : inc_sum[V_W-1:0];

    assign v_cur  = v_q[idx_q];
    assign fire   = (v_cur >= THRESH_V);
    assign v_leak = (v_cur > LEAK_V) ? (v_cur - LEAK_V) : '0;

    // The almost_empty/read-in-flight term keeps us from issuing a second read
    // against a FIFO whose last word is already on its way out.
    assign rd_en = ((state_q == IDLE) || (state_q == ACCUM)) &&
                   !lif.empty &&
                   !(lif.almost_empty && rif_q) &&
                   !drained_q &&
                   !rst;

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q | lif.step_end;
        drained_d  = drained_q;
        idx_d      = idx_q;
        wr_en      = 1'b0;
        sweep_upd  = 1'b0;
        done_pulse = 1'b0;

        if (((state_q == IDLE) || (state_q == ACCUM)) && pend_q && lif.empty && !rif_q) begin
            drained_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pend_q && !rif_q && (lif.empty || drained_q)) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end else if (!lif.empty && !drained_q) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if ((lif.empty || drained_q) && !rif_q) begin
                    state_d = IDLE;
                end
            end
            SWEEP: begin
                // A firing neuron waits for downstream room; quiet neurons never wait.
                if (!fire || !lif.full) begin
                    sweep_upd = 1'b1;
                    wr_en     = fire;
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            DONE: begin
                done_pulse = 1'b1;
                pend_d     = 1'b0;
                drained_d  = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pend_q    <= 1'b0;
            drained_q <= 1'b0;
            rif_q     <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            drained_q <= drained_d;
            rif_q     <= rd_en;
            idx_q     <= idx_d;
        end
    end

    // Accumulation and sweep never overlap: the sweep only starts with no read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NEURON; i++) begin
                v_q[i] <= '0;
            end
        end else if (sweep_upd) begin
            v_q[idx_q] <= fire ? '0 : v_leak;
        end else if (rif_q) begin
            v_q[rd_idx] <= v_inc;
        end
    end

    always_comb begin
        sidx_out = '0;
        if (wr_en) begin
            sidx_out[IDX_W-1:0] = idx_q;
        end
    end

    // Outputs are gated with rst so they drop in the same cycle reset rises.
    assign lif.r_en      = rd_en;
    assign lif.w_en      = wr_en & ~rst;
    assign lif.s_index_o = rst ? '0 : sidx_out;
    assign lif.step_done = done_pulse & ~rst;
    assign lif.busy      = (state_q != IDLE) & ~rst;

endmodule

// File: tb/tb_conv_lif_accum.sv
`ifndef SYNAPSE_INDEX
`define SYNAPSE_INDEX 15:0
`endif

module tb_conv_lif_accum;
    localparam int N      = 64;
    localparam int THR    = 100;
    localparam int WINC   = 10;
    localparam int VMAX   = 4095;
    localparam int SIDX_W = 16;
`ifdef LIF_LEAK_EN
    localparam int LEAK_M = 1;
`else
    localparam int LEAK_M = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_lif_accum_if lif ();

    conv_lif_accum #(
        .N_NEURON(64), .IDX_W(6), .V_W(12), .THRESH(100), .W_INC(10), .LEAK(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lif(lif)
    );

    int checks = 0;
    int errors = 0;
    int fifo[$];
    int model_v[N];
    int wr_log[$];
    int wr_cyc[$];
    int busy_cnt, done_cnt, rd_cnt, first_busy;
    int cyc = 0;

    typedef struct {
        int nrn;
        int cnt;
        int exp_v;
        int exp_fire;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d, expected completion", name, cyc);
    endtask

    task automatic set_flags();
        lif.empty        = (fifo.size() == 0);
        lif.almost_empty = (fifo.size() == 1);
    endtask

    // Upper word bits are random junk the DUT must ignore.
    task automatic push(input int n);
        fifo.push_back((int'($urandom_range(0, 1023)) << 6) | (n & 63));
        set_flags();
    endtask

    task automatic clear_logs();
        wr_log.delete();
        wr_cyc.delete();
        busy_cnt   = 0;
        done_cnt   = 0;
        rd_cnt     = 0;
        first_busy = -1;
    endtask

    // One clock: sample outputs at the falling edge, then act as the FIFOs after the rising edge.
    task automatic cycle();
        logic s_r, s_w, s_d, s_b;
        int   s_o, w, j;
        @(negedge clk);
        s_r = lif.r_en;
        s_w = lif.w_en;
        s_o = int'(lif.s_index_o);
        s_d = lif.step_done;
        s_b = lif.busy;
        if (s_r) begin
            chk("rd_when_empty", int'(lif.empty), 0);
            rd_cnt++;
        end
        if (s_w) begin
            chk("wr_when_full", int'(lif.full), 0);
            wr_log.push_back(s_o);
            wr_cyc.push_back(cyc);
        end
        if (s_b && !s_d) begin
            busy_cnt++;
            if (first_busy < 0) first_busy = cyc;
        end
        if (s_d) done_cnt++;
        cyc++;
        @(posedge clk);
        #1;
        lif.step_end = 1'b0;
        if (s_r && fifo.size() > 0) begin
            w = fifo.pop_front();
            lif.s_index_i = SIDX_W'(w);
            j = w & 63;
            model_v[j] = (model_v[j] + WINC > VMAX) ? VMAX : model_v[j] + WINC;
        end else begin
            lif.s_index_i = SIDX_W'($urandom_range(0, 65535));
        end
        set_flags();
    endtask

    task automatic wait_idle(input int budget);
        int quiet = 0;
        for (int k = 0; k < budget && quiet < 3; k++) begin
            cycle();
            if (fifo.size() == 0 && !lif.busy && !lif.r_en) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) timeout_fail("wait_idle");
    endtask

    task automatic run_sweep(input int budget, input int full_cycles);
        clear_logs();
        lif.full     = (full_cycles > 0);
        lif.step_end = 1'b1;
        for (int k = 0; k < budget && done_cnt == 0; k++) begin
            cycle();
            if (k + 1 == full_cycles + 2) lif.full = 1'b0;
        end
        lif.full = 1'b0;
        if (done_cnt == 0) timeout_fail("run_sweep");
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        lif.step_end = 1'b0;
        lif.full     = 1'b0;
        fifo.delete();
        set_flags();
        for (int n = 0; n < N; n++) model_v[n] = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Expected firing set is every neuron at or above threshold, in ascending order;
    // afterwards firers are zero and the rest leak (when enabled).
    task automatic check_sweep(input string tag);
        int exp_l[$];
        for (int n = 0; n < N; n++) if (model_v[n] >= THR) exp_l.push_back(n);
        chk({tag, "_nwrites"}, wr_log.size(), exp_l.size());
        for (int i = 0; i < exp_l.size() && i < wr_log.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), wr_log[i], exp_l[i]);
        for (int n = 0; n < N; n++) begin
            if (model_v[n] >= THR) model_v[n] = 0;
            else model_v[n] = (model_v[n] > LEAK_M) ? model_v[n] - LEAK_M : 0;
        end
        for (int n = 0; n < N; n++)
            chk($sformatf("%s_v%0d", tag, n), int'(dut.v_q[n]), model_v[n]);
    endtask

    initial begin
        #400us;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        int post_v;
        tbl[0] = '{3, 5, 50, 0};
        tbl[1] = '{7, 10, 100, 1};
        tbl[2] = '{1, 500, 4095, 1};
        tbl[3] = '{9, 9, 90, 0};
        tbl[4] = '{63, 11, 110, 1};
        tbl[5] = '{0, 1, 10, 0};

        // Reset state, with a non-empty FIFO so an ungated read would show up.
        rst           = 1'b1;
        lif.s_index_i = '0;
        lif.empty     = 1'b0;
        lif.almost_empty = 1'b0;
        lif.step_end  = 1'b0;
        lif.full      = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_r_en", int'(lif.r_en), 0);
        chk("rst_w_en", int'(lif.w_en), 0);
        chk("rst_s_index_o", int'(lif.s_index_o), 0);
        chk("rst_step_done", int'(lif.step_done), 0);
        chk("rst_busy", int'(lif.busy), 0);
        do_reset();

        // Single word: one read, membrane lands on the second edge after r_en.
        clear_logs();
        push(5);
        cycle();
        chk("lat_edge1_v5", int'(dut.v_q[5]), 0);
        cycle();
        chk("lat_edge2_v5", int'(dut.v_q[5]), 10);
        repeat (5) cycle();
        chk("single_word_reads", rd_cnt, 1);

        // Table: events to one neuron, then a clean timestep.
        foreach (tbl[r]) begin
            do_reset();
            for (int e = 0; e < tbl[r].cnt; e++) push(tbl[r].nrn);
            wait_idle(2000);
            chk($sformatf("tbl%0d_acc_v", r), int'(dut.v_q[tbl[r].nrn]), tbl[r].exp_v);
            run_sweep(300, 0);
            chk($sformatf("tbl%0d_sweep_len", r), busy_cnt, 64);
            chk($sformatf("tbl%0d_nwr", r), wr_log.size(), tbl[r].exp_fire);
            if (wr_log.size() > 0) chk($sformatf("tbl%0d_wr_idx", r), wr_log[0], tbl[r].nrn);
            post_v = tbl[r].exp_fire ? 0 : tbl[r].exp_v - LEAK_M;
            chk($sformatf("tbl%0d_post_v", r), int'(dut.v_q[tbl[r].nrn]), post_v);
            check_sweep($sformatf("tbl%0d", r));
            repeat (3) cycle();
            chk($sformatf("tbl%0d_done_pulses", r), done_cnt, 1);
        end

        // Downstream full for 5 cycles when neuron 0 is reached.
        do_reset();
        for (int e = 0; e < 11; e++) begin push(0); push(63); end
        wait_idle(500);
        run_sweep(300, 5);
        chk("stall_sweep_len", busy_cnt, 69);
        chk("stall_nwr", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("stall_wr0", wr_log[0], 0);
            chk("stall_wr1", wr_log[1], 63);
            chk("stall_first_wr_delay", wr_cyc[0] - first_busy, 5);
        end
        check_sweep("stall");

        // Reset in the middle of a sweep, with new events queued behind it.
        do_reset();
        for (int n = 20; n < 26; n++) for (int e = 0; e < 11; e++) push(n);
        push(40);
        push(40);
        wait_idle(500);
        clear_logs();
        lif.step_end = 1'b1;
        for (int k = 0; k < 200 && !(first_busy >= 0 && cyc - first_busy == 20); k++) begin
            if (first_busy >= 0 && fifo.size() == 0) begin push(40); push(40); push(40); end
            cycle();
        end
        if (!(first_busy >= 0 && cyc - first_busy == 20)) timeout_fail("reach_neuron20");
        chk("sweep_no_read", rd_cnt, 0);
        chk("sweep_fifo_kept", fifo.size(), 3);
        chk("pre_rst_w_en", int'(lif.w_en), 1);
        chk("pre_rst_idx", int'(lif.s_index_o), 20);
        rst = 1'b1;
        #1;
        chk("midrst_r_en", int'(lif.r_en), 0);
        chk("midrst_w_en", int'(lif.w_en), 0);
        chk("midrst_s_index_o", int'(lif.s_index_o), 0);
        chk("midrst_step_done", int'(lif.step_done), 0);
        chk("midrst_busy", int'(lif.busy), 0);
        for (int n = 0; n < N; n++) model_v[n] = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_idle(200);
        run_sweep(300, 0);
        chk("post_rst_nwr", wr_log.size(), 0);
        check_sweep("postrst");

        // Random timesteps: events trickle in, step_end lands anywhere, full toggles.
        do_reset();
        for (int s = 0; s < 6; s++) begin
            int len, sa;
            clear_logs();
            len = int'($urandom_range(30, 80));
            sa  = int'($urandom_range(10, len - 1));
            for (int c = 0; c < len && done_cnt == 0; c++) begin
                if ($urandom_range(0, 99) < 45)
                    push(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 3)));
                lif.full = ($urandom_range(0, 99) < 30);
                if (c == sa) lif.step_end = 1'b1;
                cycle();
            end
            for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
                if ($urandom_range(0, 99) < 10) push(int'($urandom_range(0, 3)));
                lif.full = ($urandom_range(0, 99) < 30);
                cycle();
            end
            lif.full = 1'b0;
            if (done_cnt == 0) timeout_fail($sformatf("rnd%0d_done", s));
            else check_sweep($sformatf("rnd%0d", s));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
